uc_booth: RTL and testbench



---
 rtl/uc_booth_if.sv | 46 ++++
 rtl/uc_booth.sv | 92 +++++++++
 tb/tb_uc_booth.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uc_booth_if.sv
// Strobe and status bundle between the Booth control unit and
// the multiplier datapath it drives.
interface uc_booth_if;
  logic start;
  logic q0;
  logic q_1;
  logic carga_M;
  logic carga_Q;
  logic carga_q0;
  logic reset_A;
  logic carga_A;
  logic suma;
  logic desplaza_A;
  logic desplaza_Q;
  logic fin;

  modport master (
    input  start,
    input  q0,
    input  q_1,
    output carga_M,
    output carga_Q,
    output carga_q0,
    output reset_A,
    output carga_A,
    output suma,
    output desplaza_A,
    output desplaza_Q,
    output fin
  );

  modport slave (
    output start,
    output q0,
    output q_1,
    input  carga_M,
    input  carga_Q,
    input  carga_q0,
    input  reset_A,
    input  carga_A,
    input  suma,
    input  desplaza_A,
    input  desplaza_Q,
    input  fin
  );
endinterface

// File: rtl/uc_booth.sv
// Radix-2 Booth multiplier control unit: sequences load,
// N examine/operate/shift iterations, then holds fin.
module uc_booth #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic       clk,
  input  logic       reset,
  uc_booth_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    TEST,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == INIT)
        cnt <= CW'(N);
      else if (state == SHIFT && cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (bus.start) nxt = INIT;
      INIT:  nxt = TEST;
      TEST:  nxt = SHIFT;
      SHIFT: nxt = (cnt == CW'(1)) ? DONE : TEST;
      DONE:  if (!bus.start) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Only TEST looks at the datapath bits; all else is Moore.
  always_comb begin
    bus.carga_M    = 1'b0;
    bus.carga_Q    = 1'b0;
    bus.carga_q0   = 1'b0;
    bus.reset_A    = 1'b0;
    bus.carga_A    = 1'b0;
    bus.suma       = 1'b1;
    bus.desplaza_A = 1'b0;
    bus.desplaza_Q = 1'b0;
    bus.fin        = 1'b0;
    unique case (state)
      INIT: begin
        bus.carga_M  = 1'b1;
        bus.carga_Q  = 1'b1;
        bus.carga_q0 = 1'b1;
        bus.reset_A  = 1'b1;
      end
      TEST: begin
        unique case (1'b1)
          (bus.q0 && !bus.q_1): begin
            bus.carga_A = 1'b1;
            bus.suma    = 1'b0;
          end
          (!bus.q0 && bus.q_1): begin
            bus.carga_A = 1'b1;
            bus.suma    = 1'b1;
          end
          default: begin
            bus.carga_A = 1'b0;
            bus.suma    = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        bus.desplaza_A = 1'b1;
        bus.desplaza_Q = 1'b1;
      end
      DONE: bus.fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_booth.sv
// Bench for uc_booth: a behavioural Booth datapath follows the
// strobes so final products can be compared with hand values.
module tb_uc_booth;

  localparam logic [8:0] O_IDLE  = 9'b0000_0_1_00_0;
  localparam logic [8:0] O_INIT  = 9'b1111_0_1_00_0;
  localparam logic [8:0] O_SHIFT = 9'b0000_0_1_11_0;
  localparam logic [8:0] O_DONE  = 9'b0000_0_1_00_1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  uc_booth_if bif ();

  uc_booth #(.N(3), .CW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  logic [3:0] da  = '0;
  logic [2:0] dq  = '0;
  logic [2:0] dm  = '0;
  logic       dq1 = 1'b0;
  logic [2:0] m_in = 3'b011;
  logic [2:0] q_in = 3'b000;

  always @(posedge clk) begin
    if (bif.carga_M)  dm  <= m_in;
    if (bif.carga_Q)  dq  <= q_in;
    if (bif.carga_q0) dq1 <= 1'b0;
    if (bif.reset_A)  da  <= '0;
    if (bif.carga_A)
      da <= bif.suma ? da + {dm[2], dm} : da - {dm[2], dm};
    if (bif.desplaza_A) begin
      da  <= {da[3], da[3:1]};
      dq  <= {da[0], dq[2:1]};
      dq1 <= dq[0];
    end
  end

  assign bif.q0  = dq[0];
  assign bif.q_1 = dq1;

  function automatic logic [8:0] outs();
    return {bif.carga_M, bif.carga_Q, bif.carga_q0, bif.reset_A,
            bif.carga_A, bif.suma, bif.desplaza_A, bif.desplaza_Q,
            bif.fin};
  endfunction

  // Strobe exclusivity, checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (bif.desplaza_A !== bif.desplaza_Q ||
          (bif.carga_A && (bif.desplaza_A || bif.carga_M ||
                           bif.carga_Q || bif.reset_A)) ||
          (bif.carga_M && bif.desplaza_A))
        $display("FAIL invariant t=%0t got=%b", $time, outs());
      else
        passed++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.start = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE)
      $display("FAIL reset_outs got=%b exp=%b", outs(), O_IDLE);
    else passed++;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (outs() !== O_IDLE)
        $display("FAIL idle_hold c=%0d got=%b exp=%b", i, outs(), O_IDLE);
      else passed++;
    end
  endtask

  logic [2:0] qv_tab [3] = '{3'b000, 3'b001, 3'b100};
  logic [2:0] ca_tab [3] = '{3'b000, 3'b011, 3'b100};
  logic [2:0] su_tab [3] = '{3'b111, 3'b110, 3'b011};
  logic [6:0] aq_tab [3] = '{7'b0000000, 7'b0000011, 7'b1110100};

  task automatic test_multiply();
    logic [8:0] e;
    for (int v = 0; v < 3; v++) begin
      q_in = qv_tab[v];
      m_in = 3'b011;
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      checks++;
      if (outs() !== O_INIT)
        $display("FAIL mul%0d_init got=%b exp=%b", v, outs(), O_INIT);
      else passed++;
      for (int i = 0; i < 3; i++) begin
        tick();
        e = ca_tab[v][i] ? {4'b0, 1'b1, su_tab[v][i], 3'b0} : O_IDLE;
        checks++;
        if (outs() !== e)
          $display("FAIL mul%0d_test%0d got=%b exp=%b", v, i + 1, outs(), e);
        else passed++;
        tick();
        checks++;
        if (outs() !== O_SHIFT)
          $display("FAIL mul%0d_shift%0d got=%b exp=%b", v, i + 1, outs(), O_SHIFT);
        else passed++;
      end
      tick();
      checks++;
      if (outs() !== O_DONE)
        $display("FAIL mul%0d_done got=%b exp=%b", v, outs(), O_DONE);
      else passed++;
      checks++;
      if ({da, dq} !== aq_tab[v])
        $display("FAIL mul%0d_product got=%b exp=%b", v, {da, dq}, aq_tab[v]);
      else passed++;
      tick();
      checks++;
      if (outs() !== O_IDLE)
        $display("FAIL mul%0d_idle got=%b exp=%b", v, outs(), O_IDLE);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    q_in = 3'b001;
    m_in = 3'b011;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (outs() !== O_SHIFT)
      $display("FAIL mid_shift2 got=%b exp=%b", outs(), O_SHIFT);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE)
      $display("FAIL mid_async got=%b exp=%b", outs(), O_IDLE);
    else passed++;
    bif.start = 1'b1;
    tick();
    checks++;
    if (outs() !== O_IDLE)
      $display("FAIL mid_held got=%b exp=%b", outs(), O_IDLE);
    else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if (outs() !== O_INIT)
      $display("FAIL mid_init got=%b exp=%b", outs(), O_INIT);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bif.fin !== 1'b0)
        $display("FAIL mid_early_fin c=%0d got=%b exp=0", i + 2, bif.fin);
      else passed++;
    end
    tick();
    checks++;
    if (outs() !== O_DONE)
      $display("FAIL mid_done got=%b exp=%b", outs(), O_DONE);
    else passed++;
    checks++;
    if ({da, dq} !== 7'b0000011)
      $display("FAIL mid_product got=%b exp=%b", {da, dq}, 7'b0000011);
    else passed++;
    bif.start = 1'b0;
    tick();
  endtask

  task automatic test_hold_start();
    q_in = 3'b111;
    m_in = 3'b011;
    bif.start = 1'b1;
    tick();
    checks++;
    if (outs() !== O_INIT)
      $display("FAIL hold_init got=%b exp=%b", outs(), O_INIT);
    else passed++;
    for (int i = 0; i < 6; i++) tick();
    tick();
    checks++;
    if (outs() !== O_DONE)
      $display("FAIL hold_done got=%b exp=%b", outs(), O_DONE);
    else passed++;
    checks++;
    if ({da, dq} !== 7'b1111101)
      $display("FAIL hold_product got=%b exp=%b", {da, dq}, 7'b1111101);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs() !== O_DONE)
        $display("FAIL hold_stay%0d got=%b exp=%b", i, outs(), O_DONE);
      else passed++;
    end
    bif.start = 1'b0;
    tick();
    checks++;
    if (outs() !== O_IDLE)
      $display("FAIL hold_idle got=%b exp=%b", outs(), O_IDLE);
    else passed++;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    checks++;
    if (outs() !== O_INIT)
      $display("FAIL hold_restart got=%b exp=%b", outs(), O_INIT);
    else passed++;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (outs() !== O_DONE)
      $display("FAIL hold_redone got=%b exp=%b", outs(), O_DONE);
    else passed++;
    tick();
  endtask

  initial begin
    bif.start = 1'b0;
    test_reset();
    test_multiply();
    test_reset_mid();
    test_hold_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
